// File: rtl/fp_mult_seq.sv
// fp_mult_seq: multicycle IEEE-754 multiplier with configurable exponent and
// fraction widths (single precision by default).
//
// The significands are multiplied by an iterative shift-add loop, one
// multiplier bit per cycle. The product is then normalised, rounded
// (round-to-nearest-even or round-toward-zero) and packed. Zero, infinity and
// NaN operands bypass the loop and are resolved when the operands are
// accepted. Subnormal inputs are flushed to zero, and no subnormal results are
// produced.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   a, b                  operands {sign, exp, frac}, 1+EXP_W+MAN_W bits wide
//   rnd_mode              0 = round-to-nearest-even, 1 = round-toward-zero
//   out_valid / out_ready result handshake with backpressure
//   result                product, held stable until it is taken
//   flags                 {invalid, overflow, underflow, inexact}
module fp_mult_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAN_W);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic op_sign, op_invalid, op_inf, op_special;
    logic [W-1:0] spec_res;
    logic [3:0] spec_flags;
    logic accept, mul_last, spec_load;

    logic sign_q, rnd_q;
    logic [EW-1:0] esum_q;
    logic [PW-1:0] mcand_q, prod_q;
    logic [N-1:0] mplier_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0] mant_q;
    logic guard_q, sticky_q;
    logic signed [EW-1:0] e_q;
    logic [W-1:0] spec_res_q;
    logic [3:0] spec_flags_q;

    logic [PW-1:0] prod_norm;
    logic signed [EW-1:0] e_norm;
    logic round_up;
    logic [N:0] mant_sum;
    logic signed [EW-1:0] e_fin;
    logic [MAN_W-1:0] frac_fin;
    logic inexact, ovf, unf;
    logic [W-1:0] round_res;
    logic [3:0] round_flags;

    // Classify the incoming operands. A zero exponent counts as zero, so
    // subnormals are flushed. NaN and inf*zero take priority over inf, and inf
    // takes priority over zero. A special result is fully decided here and
    // never enters the multiply loop.
    always_comb begin
        a_exp      = a[W-2:MAN_W];
        b_exp      = b[W-2:MAN_W];
        a_frac     = a[MAN_W-1:0];
        b_frac     = b[MAN_W-1:0];
        a_zero     = (a_exp == '0);
        b_zero     = (b_exp == '0);
        a_inf      = (a_exp == '1) && (a_frac == '0);
        b_inf      = (b_exp == '1) && (b_frac == '0);
        a_nan      = (a_exp == '1) && (a_frac != '0);
        b_nan      = (b_exp == '1) && (b_frac != '0);
        op_sign    = a[W-1] ^ b[W-1];
        op_invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        op_inf     = ~op_invalid & (a_inf | b_inf);
        op_special = op_invalid | op_inf | a_zero | b_zero;
        spec_res   = {op_sign, {(W-1){1'b0}}};
        spec_flags = 4'b0000;
        if (op_invalid) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (op_inf) begin
            spec_res = {op_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Normalise and round. The product of two [1,2) significands lies in
    // [1,4). Shifting left when the top bit is clear lines the leading one up
    // at the top in both cases, so the guard and sticky bits always come from
    // the same positions. A rounding carry-out leaves the fraction at zero and
    // bumps the exponent. The overflow and underflow limits are tested on the
    // exponent after rounding.
    always_comb begin
        prod_norm = prod_q[PW-1] ? prod_q : (prod_q << 1);
        e_norm    = $signed(esum_q) - BIAS + (prod_q[PW-1] ? EW'(1) : EW'(0));
        round_up  = ~rnd_q & guard_q & (sticky_q | mant_q[0]);
        mant_sum  = {1'b0, mant_q} + {{N{1'b0}}, round_up};
        e_fin     = e_q + (mant_sum[N] ? EW'(1) : EW'(0));
        frac_fin  = mant_sum[N] ? mant_sum[MAN_W:1] : mant_sum[MAN_W-1:0];
        inexact   = guard_q | sticky_q;
        ovf       = (e_fin >= EMAX);
        unf       = e_fin[EW-1] || (e_fin == '0);
        round_res   = {sign_q, e_fin[EXP_W-1:0], frac_fin};
        round_flags = {3'b000, inexact};
        if (ovf) begin
            round_flags = 4'b0101;
            round_res   = rnd_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            round_flags = 4'b0011;
            round_res   = {sign_q, {(W-1){1'b0}}};
        end
    end

    // State register. Reset abandons any operation that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. Special operands jump straight to DONE. DONE is left
    // only when a result is actually transferred. For a special operation,
    // out_valid is still low during the first DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = op_special ? DONE : MUL;
            MUL:     if (mul_last) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and control strobes. in_ready is gated by rst so that it
    // stays low for as long as reset is held.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        accept    = in_valid && in_ready;
        mul_last  = (state == MUL) && (cnt_q == CNT_LAST);
        spec_load = (state == DONE) && !out_valid;
    end

    // Datapath registers. The multiply loop tests the multiplier LSB, adds
    // the multiplicand when that bit is set, and then shifts the multiplicand
    // left and the multiplier right. The normal path publishes its result from
    // ROUND. The special path publishes the result it staged at accept on the
    // first DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q       <= 1'b0;
            rnd_q        <= 1'b0;
            esum_q       <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            prod_q       <= '0;
            cnt_q        <= '0;
            mant_q       <= '0;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            e_q          <= '0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            result       <= '0;
            flags        <= '0;
            out_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q       <= op_sign;
                        rnd_q        <= rnd_mode;
                        esum_q       <= EW'(a_exp) + EW'(b_exp);
                        mcand_q      <= PW'({1'b1, a_frac});
                        mplier_q     <= {1'b1, b_frac};
                        prod_q       <= '0;
                        cnt_q        <= '0;
                        spec_res_q   <= spec_res;
                        spec_flags_q <= spec_flags;
                    end
                end
                MUL: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                NORM: begin
                    mant_q   <= prod_norm[PW-1:N];
                    guard_q  <= prod_norm[N-1];
                    sticky_q <= |prod_norm[N-2:0];
                    e_q      <= e_norm;
                end
                ROUND: begin
                    result    <= round_res;
                    flags     <= round_flags;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (spec_load) begin
                        result    <= spec_res_q;
                        flags     <= spec_flags_q;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
